// File: rtl/bet_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bet_pkg
//  Description : Balanced-ternary (BET) trit codes, the trit type and
//                conversion helpers shared by the trit datapath blocks.
//  Revision    : 1.0  initial release
// ============================================================================
package bet_pkg;

    typedef logic [1:0] trit_t;

    localparam trit_t BET_NEG     = 2'b01;
    localparam trit_t BET_ZERO    = 2'b11;
    localparam trit_t BET_POS     = 2'b10;
    localparam trit_t BET_ILLEGAL = 2'b00;

    // The upstream latch treats the illegal code as zero; do the same here.
    function automatic trit_t bet_sanitize(input trit_t t);
        return (t == BET_ILLEGAL) ? BET_ZERO : t;
    endfunction

    function automatic int bet_to_int(input trit_t t);
        case (t)
            BET_NEG: return -1;
            BET_POS: return 1;
            default: return 0;
        endcase
    endfunction

    function automatic trit_t int_to_bet(input int v);
        if (v < 0)
            return BET_NEG;
        else if (v > 0)
            return BET_POS;
        else
            return BET_ZERO;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bet_trit_half_adder.sv
`default_nettype none
// ============================================================================
//  Module      : bet_trit_half_adder
//  Description : Single-trit balanced-ternary adder. a + b in {-2..2} is
//                folded into a sum trit and a carry trit, never emitting 00.
//  Revision    : 1.0  initial release
// ============================================================================
module bet_trit_half_adder
    import bet_pkg::*;
(
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [1:0] sum,
    output logic [1:0] carry
);

    int w_total;

    // Fold the -2/+2 cases into an opposite-sign sum with a carry.
    always_comb begin
        w_total = bet_to_int(a) + bet_to_int(b);
        sum     = int_to_bet(w_total);
        carry   = BET_ZERO;
        if (w_total > 1) begin
            sum   = BET_NEG;
            carry = BET_POS;
        end else if (w_total < -1) begin
            sum   = BET_POS;
            carry = BET_NEG;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bet_trit_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : bet_trit_accumulator
//  Description : Accumulates a stream of BET trits into an NTRITS-wide
//                balanced-ternary register with wrap or saturate on
//                overflow, a carry trit report and a sticky illegal-code flag.
//  Revision    : 1.0  initial release
// ============================================================================
module bet_trit_accumulator
    import bet_pkg::*;
#(
    parameter int NTRITS   = 4,
    parameter bit SATURATE = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [1:0]            in_trit,
    input  logic                  clear,
    output logic [2*NTRITS-1:0]   acc_out,
    output logic                  out_valid,
    output logic [1:0]            carry_out,
    output logic                  err
);

    localparam logic [2*NTRITS-1:0] c_zero_word = {NTRITS{BET_ZERO}};

    logic [2*NTRITS-1:0] r_acc;
    logic                r_out_valid;
    logic [1:0]          r_carry;
    logic                r_err;

    trit_t               w_in;
    logic                w_illegal;
    trit_t               w_chain [0:NTRITS];
    logic [2*NTRITS-1:0] w_sum;
    logic                w_overflow;
    logic [2*NTRITS-1:0] w_next;
    logic [2*NTRITS-1:0] w_clear_word;

    assign w_in       = bet_sanitize(in_trit);
    assign w_illegal  = (in_trit == BET_ILLEGAL);
    assign w_chain[0] = w_in;

    // Ripple chain: trit 0 adds the input, each higher trit adds the carry below.
    generate
        for (genvar gi = 0; gi < NTRITS; gi++) begin : g_trit
            bet_trit_half_adder u_ha (
                .a     (r_acc[2*gi +: 2]),
                .b     (w_chain[gi]),
                .sum   (w_sum[2*gi +: 2]),
                .carry (w_chain[gi+1])
            );
        end
    endgenerate

    // A single-trit step can only overflow by one, so the register already
    // holds the max/min value when saturation has to hold it.
    assign w_overflow = (w_chain[NTRITS] != BET_ZERO);
    assign w_next     = (SATURATE && w_overflow) ? r_acc : w_sum;

    // Value loaded when clear and a valid trit arrive together.
    always_comb begin
        w_clear_word      = c_zero_word;
        w_clear_word[1:0] = w_in;
    end

    // Accumulator, carry report, valid pulse and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= c_zero_word;
            r_out_valid <= 1'b0;
            r_carry     <= BET_ZERO;
            r_err       <= 1'b0;
        end else if (clear) begin
            r_acc       <= in_valid ? w_clear_word : c_zero_word;
            r_out_valid <= in_valid;
            r_carry     <= BET_ZERO;
            r_err       <= in_valid & w_illegal;
        end else if (in_valid) begin
            r_acc       <= w_next;
            r_out_valid <= 1'b1;
            r_carry     <= w_chain[NTRITS];
            r_err       <= r_err | w_illegal;
        end else begin
            r_out_valid <= 1'b0;
            r_carry     <= BET_ZERO;
        end
    end

    assign acc_out   = r_acc;
    assign out_valid = r_out_valid;
    assign carry_out = r_carry;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bet_trit_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bet_trit_accumulator
//  Description : Bench for bet_trit_accumulator with NTRITS=2. A wrapping and
//                a saturating instance share one input stream and are compared
//                every cycle against an integer model of the accumulator.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bet_trit_accumulator;

    localparam int NT      = 2;
    localparam int c_span  = 9;   // 3^NT
    localparam int c_max   = 4;
    localparam int c_min   = -4;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic [1:0]      in_trit;
    logic            clear;
    logic [2*NT-1:0] acc_w, acc_s;
    logic            ov_w, ov_s;
    logic [1:0]      cy_w, cy_s;
    logic            err_w, err_s;

    int    checks = 0;
    int    errors = 0;
    string phase  = "init";

    // Reference model state: index 0 wraps, index 1 saturates.
    int m_acc   [2];
    int m_carry [2];
    bit m_valid;
    bit m_err;

    always #5 clk = ~clk;

    bet_trit_accumulator #(.NTRITS(NT), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_trit(in_trit), .clear(clear),
        .acc_out(acc_w), .out_valid(ov_w), .carry_out(cy_w), .err(err_w)
    );

    bet_trit_accumulator #(.NTRITS(NT), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_trit(in_trit), .clear(clear),
        .acc_out(acc_s), .out_valid(ov_s), .carry_out(cy_s), .err(err_s)
    );

    function automatic int trit_val(input logic [1:0] t);
        if (t == 2'b01) return -1;
        if (t == 2'b10) return 1;
        return 0;
    endfunction

    function automatic int word_val(input logic [2*NT-1:0] w);
        int v   = 0;
        int wgt = 1;
        for (int i = 0; i < NT; i++) begin
            v   += wgt * trit_val(w[2*i +: 2]);
            wgt *= 3;
        end
        return v;
    endfunction

    function automatic int has_illegal(input logic [2*NT-1:0] w);
        for (int i = 0; i < NT; i++)
            if (w[2*i +: 2] == 2'b00) return 1;
        return 0;
    endfunction

    function automatic logic [1:0] code_of(input int c);
        if (c < 0) return 2'b01;
        if (c > 0) return 2'b10;
        return 2'b11;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s [%s]: observed %0d expected %0d", tag, phase, obs, exp);
        end
    endtask

    task automatic model_update(input logic v, input logic [1:0] t, input logic c, input logic r);
        int s;
        if (r) begin
            for (int k = 0; k < 2; k++) begin m_acc[k] = 0; m_carry[k] = 0; end
            m_valid = 0;
            m_err   = 0;
        end else if (c) begin
            for (int k = 0; k < 2; k++) begin
                m_acc[k]   = v ? trit_val(t) : 0;
                m_carry[k] = 0;
            end
            m_valid = v;
            m_err   = v && (t == 2'b00);
        end else if (v) begin
            for (int k = 0; k < 2; k++) begin
                s          = m_acc[k] + trit_val(t);
                m_carry[k] = 0;
                if (s > c_max) begin
                    m_carry[k] = 1;
                    s = (k == 1) ? c_max : s - c_span;
                end else if (s < c_min) begin
                    m_carry[k] = -1;
                    s = (k == 1) ? c_min : s + c_span;
                end
                m_acc[k] = s;
            end
            m_valid = 1;
            m_err   = m_err || (t == 2'b00);
        end else begin
            m_valid = 0;
            for (int k = 0; k < 2; k++) m_carry[k] = 0;
        end
    endtask

    task automatic check_all();
        check("wrap_acc",       word_val(acc_w),    m_acc[0]);
        check("wrap_no00",      has_illegal(acc_w), 0);
        check("wrap_carry",     int'(cy_w),         int'(code_of(m_carry[0])));
        check("wrap_out_valid", int'(ov_w),         int'(m_valid));
        check("wrap_err",       int'(err_w),        int'(m_err));
        check("sat_acc",        word_val(acc_s),    m_acc[1]);
        check("sat_no00",       has_illegal(acc_s), 0);
        check("sat_carry",      int'(cy_s),         int'(code_of(m_carry[1])));
        check("sat_out_valid",  int'(ov_s),         int'(m_valid));
        check("sat_err",        int'(err_s),        int'(m_err));
    endtask

    task automatic step(input logic v, input logic [1:0] t, input logic c, input logic r);
        @(negedge clk);
        in_valid = v;
        in_trit  = t;
        clear    = c;
        rst      = r;
        @(posedge clk);
        #1;
        model_update(v, t, c, r);
        check_all();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_trit = 2'b11; clear = 1'b0;

        // Reset, applied mid-stream and on top of clear+valid.
        phase = "reset";
        step(0, 2'b11, 0, 1);
        step(1, 2'b10, 0, 0);
        step(1, 2'b10, 0, 0);
        step(1, 2'b10, 1, 1);
        step(1, 2'b01, 0, 1);
        check("reset_word", int'(acc_w), 8'hF);

        // Five +1 trits: 1..4 then wrap to -4 (saturating copy holds at 4).
        phase = "wrap_up";
        repeat (5) step(1, 2'b10, 0, 0);
        check("wrap_up_min_code", int'(acc_w), 4'b0101);
        check("sat_up_max_code",  int'(acc_s), 4'b1010);

        // From zero, five -1 trits: wrap to +4 with carry 01.
        phase = "wrap_down";
        step(0, 2'b11, 1, 0);
        repeat (5) step(1, 2'b01, 0, 0);
        check("wrap_down_max_code", int'(acc_w), 4'b1010);

        // Idle cycles then explicit zero trits.
        phase = "idle_zero";
        repeat (3) step(0, 2'b10, 0, 0);
        repeat (3) step(1, 2'b11, 0, 0);

        // Illegal code: treated as zero, err sticky until clear.
        phase = "illegal";
        step(1, 2'b00, 0, 0);
        step(0, 2'b00, 0, 0);
        step(1, 2'b01, 0, 0);
        step(1, 2'b10, 1, 0);
        check("clear_load_code", int'(acc_w), 4'b1110);
        step(1, 2'b00, 1, 0);

        // Six +1 trits from zero: saturating copy holds at max.
        phase = "saturate";
        step(0, 2'b11, 1, 0);
        repeat (6) step(1, 2'b10, 0, 0);
        step(1, 2'b01, 0, 0);

        // Randomized traffic.
        phase = "random";
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 99) < 70,
                 2'($urandom_range(0, 3)),
                 $urandom_range(0, 99) < 5,
                 $urandom_range(0, 99) < 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
